data_memory_ws: RTL and testbench

Parametrised, clocked successor to the single-cycle data memory: byte-addressed, little-endian, with byte/half/word/doubleword accesses, sign/zero extension on loads, alignment and range checking, and a configurable wait-state request/ready handshake. Sits on the memory stage of the ARMv8 datapath, between the ALU address output and the write-back mux. The control unit holds the processor stalled while `busy` is high.

---
 rtl/data_memory_ws_if.sv | 26 ++
 rtl/data_memory_ws.sv | 228 ++++++++++++++++++++++
 tb/tb_data_memory_ws.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ws_if.sv
// data_memory_ws_if: request/response bundle of the wait-state data memory.
// master drives requests, slave returns load data and status.
interface data_memory_ws_if;
  logic        memRd;
  logic        memWr;
  logic [63:0] dir;
  logic [63:0] dataWr;
  logic [1:0]  size;
  logic        signExt;
  logic [63:0] dataRd;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output memRd, memWr, dir, dataWr,
    output size, signExt,
    input  dataRd, ready, busy, err
  );

  modport slave (
    input  memRd, memWr, dir, dataWr,
    input  size, signExt,
    output dataRd, ready, busy, err
  );
endinterface

// File: rtl/data_memory_ws.sv
// data_memory_ws: byte-addressed little-endian data memory with
// configurable wait states and alignment/range checking.
module data_memory_ws #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  data_memory_ws_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        sext_q, sext_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] dir_q, dir_d;
  logic [63:0] wdat_q, wdat_d;

  logic [63:0] data_rd_q, data_rd_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [DEPTH];
  logic [63:0] mem_d [DEPTH];

  logic        accept;
  logic        access;

  logic        a_rd, a_wr, a_sext;
  logic [1:0]  a_size;
  logic [63:0] a_dir, a_wdat;

  logic [AW-1:0] idx;
  logic [5:0]    sh;
  logic [2:0]    amask;
  logic [7:0]    nb;
  logic [7:0]    be;
  logic          mis, oor, bad;
  logic [63:0]   raw, ext, wsh;

  // FSM state register; reset also clears the wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: accept in IDLE, count down in WAIT, single RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.memRd | bus.memWr) begin
          accept = 1'b1;
          if (WC == 4'd0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WC;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    access = (state_d == S_RESP) && (state_q != S_RESP);
  end

  // status outputs derived from state; data and err are registered
  always_comb begin
    bus.busy   = (state_q != S_IDLE);
    bus.ready  = (state_q == S_RESP);
    bus.err    = err_q;
    bus.dataRd = data_rd_q;
  end

  // request operands: live inputs when accessing straight from IDLE
  always_comb begin
    if (state_q == S_IDLE) begin
      a_rd   = bus.memRd;
      a_wr   = bus.memWr;
      a_sext = bus.signExt;
      a_size = bus.size;
      a_dir  = bus.dir;
      a_wdat = bus.dataWr;
    end else begin
      a_rd   = rd_q;
      a_wr   = wr_q;
      a_sext = sext_q;
      a_size = size_q;
      a_dir  = dir_q;
      a_wdat = wdat_q;
    end
  end

  // address decode, checks, load extraction and store merge
  always_comb begin
    rd_d      = rd_q;
    wr_d      = wr_q;
    sext_d    = sext_q;
    size_d    = size_q;
    dir_d     = dir_q;
    wdat_d    = wdat_q;
    data_rd_d = data_rd_q;
    err_d     = 1'b0;
    mem_d     = mem_q;

    if (accept) begin
      rd_d   = bus.memRd;
      wr_d   = bus.memWr;
      sext_d = bus.signExt;
      size_d = bus.size;
      dir_d  = bus.dir;
      wdat_d = bus.dataWr;
    end

    idx = a_dir[AW+2:3];
    sh  = {a_dir[2:0], 3'b000};
    raw = mem_q[idx] >> sh;
    wsh = a_wdat << sh;

    unique case (a_size)
      2'b00: begin
        amask = 3'b000;
        nb    = 8'h01;
        ext   = a_sext ? {{56{raw[7]}}, raw[7:0]}
                       : {56'd0, raw[7:0]};
      end
      2'b01: begin
        amask = 3'b001;
        nb    = 8'h03;
        ext   = a_sext ? {{48{raw[15]}}, raw[15:0]}
                       : {48'd0, raw[15:0]};
      end
      2'b10: begin
        amask = 3'b011;
        nb    = 8'h0F;
        ext   = a_sext ? {{32{raw[31]}}, raw[31:0]}
                       : {32'd0, raw[31:0]};
      end
      default: begin
        amask = 3'b111;
        nb    = 8'hFF;
        ext   = raw;
      end
    endcase

    be  = nb << a_dir[2:0];
    mis = |(a_dir[2:0] & amask);
    oor = |(a_dir >> (AW + 3));
    bad = mis | oor | (a_rd & a_wr);

    if (access) begin
      err_d = bad;
      if (bad) begin
        data_rd_d = '0;
      end else if (a_rd) begin
        data_rd_d = ext;
      end else if (a_wr) begin
        for (int b = 0; b < 8; b++) begin
          if (be[b]) begin
            mem_d[idx][8*b +: 8] = wsh[8*b +: 8];
          end
        end
      end
    end
  end

  // request latch, response registers and the storage array
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      sext_q    <= 1'b0;
      size_q    <= '0;
      dir_q     <= '0;
      wdat_q    <= '0;
      data_rd_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      sext_q    <= sext_d;
      size_q    <= size_d;
      dir_q     <= dir_d;
      wdat_q    <= wdat_d;
      data_rd_q <= data_rd_d;
      err_q     <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// tb_data_memory_ws: scoreboard bench over three wait-state settings
// (0, 3 and 4) sharing one stimulus bus selected by sel.
module tb_data_memory_ws;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        sx = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [1:0]  sz = 2'd0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;

  data_memory_ws_if b0 ();
  data_memory_ws_if b1 ();
  data_memory_ws_if b2 ();

  data_memory_ws #(.DEPTH(32), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(rst), .bus(b0.slave));
  data_memory_ws #(.DEPTH(32), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .reset(rst), .bus(b1.slave));
  data_memory_ws #(.DEPTH(32), .WAIT_CYCLES(4)) u2 (
    .clk(clk), .reset(rst), .bus(b2.slave));

  assign b0.memRd   = rd & (sel == 2'd0);
  assign b0.memWr   = wr & (sel == 2'd0);
  assign b0.dir     = addr;
  assign b0.dataWr  = wdata;
  assign b0.size    = sz;
  assign b0.signExt = sx;
  assign b1.memRd   = rd & (sel == 2'd1);
  assign b1.memWr   = wr & (sel == 2'd1);
  assign b1.dir     = addr;
  assign b1.dataWr  = wdata;
  assign b1.size    = sz;
  assign b1.signExt = sx;
  assign b2.memRd   = rd & (sel == 2'd2);
  assign b2.memWr   = wr & (sel == 2'd2);
  assign b2.dir     = addr;
  assign b2.dataWr  = wdata;
  assign b2.size    = sz;
  assign b2.signExt = sx;

  logic        rdy_s, busy_s, err_s;
  logic [63:0] dat_s;

  always_comb begin
    case (sel)
      2'd0: begin
        rdy_s = b0.ready; busy_s = b0.busy;
        err_s = b0.err;   dat_s  = b0.dataRd;
      end
      2'd1: begin
        rdy_s = b1.ready; busy_s = b1.busy;
        err_s = b1.err;   dat_s  = b1.dataRd;
      end
      default: begin
        rdy_s = b2.ready; busy_s = b2.busy;
        err_s = b2.err;   dat_s  = b2.dataRd;
      end
    endcase
  end

  typedef struct {
    logic        err;
    logic        chk;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   rdy_t[$];
  int   cyc = 0;
  int   bcnt = 0;
  int   n_done = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input logic [1:0] s);
    return (s == 2'd0) ? 0 : (s == 2'd1) ? 3 : 4;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // monitor: predict acceptances, score completions
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst) begin
      sb.delete();
      acc_q.delete();
      bcnt = 0;
    end else begin
      if (busy_s) bcnt++;
      if (!rdy_s && err_s) check("err_outside_resp", err_s, 0);
      if (rdy_s) begin
        if (sb.size() == 0 || acc_q.size() == 0) begin
          check("spurious_ready", rdy_s, 0);
        end else begin
          e = sb.pop_front();
          a = acc_q.pop_front();
          check("err", err_s, e.err);
          if (e.chk) check("dataRd", dat_s, e.data);
          check("latency", cyc - a, wc(sel));
          check("busy_len", bcnt, wc(sel) + 1);
        end
        bcnt = 0;
        n_done++;
        if (sel == 2'd2) rdy_t.push_back(cyc);
      end
      if ((rd | wr) && !busy_s) acc_q.push_back(cyc + 1);
    end
  end

  task automatic access(input logic [1:0] s,
                        input logic r, input logic w,
                        input logic [63:0] a,
                        input logic [63:0] d,
                        input logic [1:0] z,
                        input logic x,
                        input logic ee,
                        input logic chk,
                        input logic [63:0] ed);
    int target;
    exp_t e;
    @(posedge clk); #1;
    sel = s; rd = r; wr = w;
    addr = a; wdata = d; sz = z; sx = x;
    e.err = ee; e.chk = chk; e.data = ed;
    sb.push_back(e);
    target = n_done + 1;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 40 && n_done < target; i++) begin
      @(negedge clk); #1;
    end
    if (n_done < target) check("timeout", n_done, target);
    @(posedge clk); #1;
    check("ready_idle", rdy_s, 0);
  endtask

  initial begin
    int n0;
    exp_t e;
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n0;
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      check("rst_busy", busy_s, 0);
      check("rst_ready", rdy_s, 0);
      check("rst_err", err_s, 0);
      check("rst_data", dat_s, 0);
    end
    rst = 1'b0;

    // reset in the middle of a waiting write (3 wait states)
    access(1, 0, 1, 64'h18, 64'hA5A55A5A01234567, 3, 0, 0, 0, 0);
    access(1, 1, 0, 64'h18, 0, 3, 0, 0, 1, 64'hA5A55A5A01234567);
    @(posedge clk); #1;
    sel = 2'd1; wr = 1'b1; addr = 64'h10;
    wdata = 64'hCAFEF00DCAFEF00D; sz = 2'd3;
    e.err = 1'b0; e.chk = 1'b0; e.data = '0;
    sb.push_back(e);
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    check("busy_in_wait", busy_s, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", busy_s, 0);
    check("rst_mid_ready", rdy_s, 0);
    check("rst_mid_data", dat_s, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    access(1, 1, 0, 64'h10, 0, 3, 0, 0, 1, 64'h0);
    access(1, 1, 0, 64'h18, 0, 3, 0, 0, 1, 64'h0);

    // zero wait states: round trip, lanes, extension
    access(0, 0, 1, 64'h08, 64'h1122334455667788, 3, 0, 0, 0, 0);
    access(0, 1, 0, 64'h08, 0, 3, 0, 0, 1, 64'h1122334455667788);
    access(0, 0, 1, 64'h0B, 64'h80, 0, 0, 0, 0, 0);
    access(0, 1, 0, 64'h0B, 0, 0, 1, 0, 1, 64'hFFFFFFFFFFFFFF80);
    access(0, 1, 0, 64'h0B, 0, 0, 0, 0, 1, 64'h0000000000000080);
    access(0, 1, 0, 64'h08, 0, 3, 0, 0, 1, 64'h1122334480667788);
    access(0, 0, 1, 64'h0E, 64'hBEEF, 1, 0, 0, 0, 0);
    access(0, 1, 0, 64'h0C, 0, 2, 1, 0, 1, 64'hFFFFFFFFBEEF3344);
    access(0, 1, 0, 64'h0E, 0, 1, 0, 0, 1, 64'h000000000000BEEF);

    // error cases leave the array untouched
    access(0, 0, 1, 64'h0A, 64'hDEADBEEF, 2, 0, 1, 1, 64'h0);
    access(0, 1, 0, 64'h0A, 0, 2, 0, 1, 1, 64'h0);
    access(0, 1, 0, 64'h100, 0, 3, 0, 1, 1, 64'h0);
    access(0, 1, 1, 64'h08, 64'hFFFFFFFFFFFFFFFF, 3, 0, 1, 1, 64'h0);
    access(0, 0, 1, 64'h100, 64'h55, 0, 0, 1, 1, 64'h0);
    access(0, 1, 0, 64'h8000000000000008, 0, 3, 0, 1, 1, 64'h0);
    access(0, 1, 0, 64'h00, 0, 3, 0, 0, 1, 64'h0);
    access(0, 1, 0, 64'h08, 0, 3, 0, 0, 1, 64'hBEEF334480667788);

    // top of the address range
    access(0, 0, 1, 64'hFF, 64'hF8, 0, 0, 0, 0, 0);
    access(0, 1, 0, 64'hFF, 0, 0, 1, 0, 1, 64'hFFFFFFFFFFFFFFF8);
    access(0, 1, 0, 64'hF8, 0, 3, 0, 0, 1, 64'hF800000000000000);

    // held read with 4 wait states: two accesses, period W+2
    rdy_t.delete();
    e.err = 1'b0; e.chk = 1'b1; e.data = '0;
    sb.push_back(e);
    sb.push_back(e);
    n0 = n_done;
    @(posedge clk); #1;
    sel = 2'd2; rd = 1'b1; addr = 64'h20; sz = 2'd3; sx = 1'b0;
    for (int i = 0; i < 60 && n_done < n0 + 2; i++) begin
      @(negedge clk); #1;
    end
    rd = 1'b0;
    if (n_done < n0 + 2) check("held_timeout", n_done, n0 + 2);
    if (rdy_t.size() >= 2)
      check("ready_period", rdy_t[1] - rdy_t[0], 6);
    else
      check("ready_count", rdy_t.size(), 2);
    repeat (20) @(posedge clk);
    #1;
    check("no_extra_ready", n_done, n0 + 2);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
